// File: rtl/hb_pkg.sv
// Shared types and reset-group masks for the staged reset sequencer.
package hb_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRelClk  = 3'd1,
    StRelQuad = 3'd2,
    StRelPid  = 3'd3,
    StRun     = 3'd4,
    StFault   = 3'd5
  } seq_state_e;

  localparam logic [31:0] PWM_MASK    = 32'h000000FF;
  localparam logic [31:0] QUAD_MASK   = 32'h000FFF00;
  localparam logic [31:0] PID_MASK    = 32'h0FF00000;
  localparam logic [31:0] PIDCLK_MASK = 32'h10000000;
  localparam logic [31:0] SPARE_MASK  = 32'hE0000000;

  // Held-in-reset mask per state; groups are released cumulatively in dependency order.
  function automatic logic [31:0] stage_mask(seq_state_e st);
    logic [31:0] m;
    m = 32'hFFFFFFFF;
    case (st)
      StRelClk:  m = ~PIDCLK_MASK;
      StRelQuad: m = ~(PIDCLK_MASK | QUAD_MASK);
      StRelPid:  m = ~(PIDCLK_MASK | QUAD_MASK | PID_MASK);
      StRun:     m = SPARE_MASK;
      default:   m = 32'hFFFFFFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
interface reset_sequencer_if;
  logic        tick;
  logic [31:0] wd_reset;
  logic        e_stop;
  logic        arm;
  logic [31:0] seq_reset;
  logic        ready;
  logic        fault_latched;
  logic [2:0]  state_o;

  modport master (
    output tick, wd_reset, e_stop, arm,
    input  seq_reset, ready, fault_latched, state_o
  );

  modport slave (
    input  tick, wd_reset, e_stop, arm,
    output seq_reset, ready, fault_latched, state_o
  );
endinterface

// File: rtl/reset_sequencer_stage_timer.sv
// Saturating 8-bit slow-tick dwell counter; done flags the tick that completes the dwell.
module stage_timer #(
  parameter int unsigned STAGE_TICKS = 10
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] Limit = 8'(STAGE_TICKS);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (tick && (count_q < Limit)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Independent of clear so the FSM can use it to decide the next state.
  assign done = tick && (count_q >= (Limit - 8'd1));

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset-release controller: releases PID clock, quad, PID, PWM in order after arm.
module reset_sequencer
  import hb_pkg::*;
#(
  parameter int unsigned STAGE_TICKS = 10
) (
  input  logic               clk_50Mhz,
  input  logic               rst_n,
  reset_sequencer_if.slave   bus
);

  seq_state_e  state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] seq_q;
  logic        ready_q;
  logic        trigger;
  logic        timer_clear;
  logic        timer_done;

  assign trigger = !bus.e_stop || (bus.wd_reset[7:0] == 8'hFF);

  stage_timer #(
    .STAGE_TICKS(STAGE_TICKS)
  ) u_stage_timer (
    .clk_50Mhz(clk_50Mhz),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .tick     (bus.tick),
    .done     (timer_done)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (!trigger && bus.arm) begin
          state_d = StRelClk;
          fault_d = 1'b0;
        end
      end
      StRelClk:  if (trigger) state_d = StFault; else if (timer_done) state_d = StRelQuad;
      StRelQuad: if (trigger) state_d = StFault; else if (timer_done) state_d = StRelPid;
      StRelPid:  if (trigger) state_d = StFault; else if (timer_done) state_d = StRun;
      StRun:     if (trigger) state_d = StFault;
      StFault:   if (!trigger && timer_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if ((state_d == StFault) && (state_q != StFault)) begin
      fault_d = 1'b1;
    end
    // A trigger restarts the clean-interval count in FAULT; elsewhere it is harmless.
    timer_clear = (state_d != state_q) || trigger;
  end

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fault_q <= 1'b0;
      seq_q   <= 32'hFFFFFFFF;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      seq_q   <= stage_mask(state_d) | bus.wd_reset;
      ready_q <= (state_d == StRun);
    end
  end

  assign bus.seq_reset     = seq_q;
  assign bus.ready         = ready_q;
  assign bus.fault_latched = fault_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed plus randomized bench for reset_sequencer against a behavioural model.
module tb_reset_sequencer;

  localparam int ST = 4;

  logic clk_50Mhz;
  logic rst_n;
  reset_sequencer_if bus();

  reset_sequencer #(
    .STAGE_TICKS(ST)
  ) dut (
    .clk_50Mhz(clk_50Mhz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk_50Mhz = 1'b0;
  always #10 clk_50Mhz = ~clk_50Mhz;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1..3 releasing, 4 run, 5 fault; n_rel groups released = phase (1..4).
  int          m_phase;
  int          m_cnt;
  bit          m_flt;
  logic [31:0] m_wd;
  logic [31:0] grp [4] = '{32'h10000000, 32'h000FFF00, 32'h0FF00000, 32'h000000FF};

  function automatic logic [31:0] exp_seq();
    logic [31:0] held = 32'hFFFFFFFF;
    if (m_phase >= 1 && m_phase <= 4)
      for (int k = 0; k < m_phase; k++) held &= ~grp[k];
    return held | m_wd;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_cnt = 0; m_flt = 0; m_wd = '0;
  endfunction

  function automatic void model_step(bit tk, bit ar, bit es, logic [31:0] wd);
    bit trig = !es || (wd[7:0] == 8'hFF);
    m_wd = wd;
    if (m_phase == 0) begin
      if (ar && !trig) begin m_phase = 1; m_cnt = 0; m_flt = 0; end
    end else if (m_phase == 5) begin
      if (trig) m_cnt = 0;
      else if (tk) begin
        m_cnt++;
        if (m_cnt == ST) begin m_phase = 0; m_cnt = 0; end
      end
    end else if (trig) begin
      m_phase = 5; m_cnt = 0; m_flt = 1;
    end else if (m_phase < 4 && tk) begin
      m_cnt++;
      if (m_cnt == ST) begin m_phase++; m_cnt = 0; end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 0;
  always @(negedge clk_50Mhz) begin
    if (cmp_en) begin
      chk("model seq_reset", bus.seq_reset, exp_seq());
      chk("model ready", 32'(bus.ready), 32'(m_phase == 4));
      chk("model fault_latched", 32'(bus.fault_latched), 32'(m_flt));
      chk("model state_o", 32'(bus.state_o), 32'(m_phase));
    end
  end

  task automatic step(input bit tk, input bit ar, input bit es, input logic [31:0] wd);
    bus.tick = tk; bus.arm = ar; bus.e_stop = es; bus.wd_reset = wd;
    @(posedge clk_50Mhz);
    if (rst_n) model_step(tk, ar, es, wd);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 1, '0);
      step(0, 0, 1, '0);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] seq, input bit rdy, input bit fl,
                     input logic [2:0] st);
    chk({name, " seq_reset"}, bus.seq_reset, seq);
    chk({name, " ready"}, 32'(bus.ready), 32'(rdy));
    chk({name, " fault_latched"}, 32'(bus.fault_latched), 32'(fl));
    chk({name, " state_o"}, 32'(bus.state_o), 32'(st));
  endtask

  initial begin
    logic [31:0] wd;
    bit tk, ar, es;
    model_reset();
    rst_n = 1'b0;
    bus.tick = 0; bus.arm = 0; bus.e_stop = 1; bus.wd_reset = '0;
    cmp_en = 1;
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    lit("reset", 32'hFFFFFFFF, 0, 0, 3'd0);
    rst_n = 1'b1;
    step(0, 0, 1, '0);

    // Arm and walk through the release stages.
    step(0, 1, 1, '0);
    lit("arm", 32'hEFFFFFFF, 0, 0, 3'd1);
    ticks(3);
    lit("rel_clk dwell", 32'hEFFFFFFF, 0, 0, 3'd1);
    step(1, 0, 1, '0);
    lit("tick4", 32'hEFF000FF, 0, 0, 3'd2);
    ticks(3);
    step(1, 0, 1, '0);
    lit("tick8", 32'hE00000FF, 0, 0, 3'd3);
    ticks(3);
    lit("pre run", 32'hE00000FF, 0, 0, 3'd3);
    step(1, 0, 1, '0);
    lit("tick12", 32'hE0000000, 1, 0, 3'd4);

    step(0, 0, 1, 32'h00000100);
    lit("run wd bit", 32'hE0000100, 1, 0, 3'd4);
    step(0, 0, 0, '0);
    lit("estop", 32'hFFFFFFFF, 0, 1, 3'd5);
    ticks(3);
    lit("fault dwell", 32'hFFFFFFFF, 0, 1, 3'd5);
    step(1, 0, 1, '0);
    lit("fault exit", 32'hFFFFFFFF, 0, 1, 3'd0);

    step(0, 1, 0, '0);
    lit("idle arm trig", 32'hFFFFFFFF, 0, 1, 3'd0);
    step(0, 1, 1, '0);
    lit("rearm", 32'hEFFFFFFF, 0, 0, 3'd1);
    ticks(4);
    lit("quad", 32'hEFF000FF, 0, 0, 3'd2);
    step(0, 0, 1, 32'h000000FF);
    lit("wd fault", 32'hFFFFFFFF, 0, 1, 3'd5);
    ticks(3);
    step(0, 0, 0, '0);
    ticks(3);
    lit("glitch restart", 32'hFFFFFFFF, 0, 1, 3'd5);
    step(1, 0, 1, '0);
    lit("glitch exit", 32'hFFFFFFFF, 0, 1, 3'd0);

    // Asynchronous reset in the middle of REL_PID.
    step(0, 1, 1, '0);
    ticks(8);
    lit("rel_pid", 32'hE00000FF, 0, 0, 3'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1 lit("async rst", 32'hFFFFFFFF, 0, 0, 3'd0);
    #4 rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      tk = ($urandom_range(0, 2) == 0);
      ar = ($urandom_range(0, 9) == 0);
      es = ($urandom_range(0, 149) != 0);
      case ($urandom_range(0, 19))
        0: begin wd = $urandom; if (wd[7:0] == 8'hFF) wd[7:0] = 8'hFE; end
        1: wd = ($urandom_range(0, 4) == 0) ? 32'h000000FF : 32'h00000000;
        default: wd = '0;
      endcase
      step(tk, ar, es, wd);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk_50Mhz);
    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
